multi_bin_sort_sequencer: RTL and testbench

- Successor to the single on/off servo control: turns colour-class detections into timed servo moves to one of NUM_CLASSES bin positions.
- Sits between the colour classifier and the servo pin.
- Queues detections in a small FIFO and runs each one through a sequence: move to the bin, dwell, return home.
- PWM pulse width changes only on PWM period boundaries, so pulses are never glitched.

---
 rtl/multi_bin_sort_sequencer_pkg.sv | 31 +++
 rtl/multi_bin_sort_sequencer_servo_pwm_gen.sv | 48 ++++
 rtl/multi_bin_sort_sequencer.sv | 136 +++++++++++++
 tb/tb_multi_bin_sort_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_bin_sort_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// sort_seq_pkg : shared state type, bin-width helpers and datapath widths
// Revision 1.0
// ============================================================================
package sort_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE   = 2'd1,
        HOLD   = 2'd2,
        RETURN = 2'd3
    } state_t;

    // Width of the tick/us/period counters and the pulse-width datapath.
    localparam int unsigned CNT_W = 32;

    function automatic logic [CNT_W-1:0] bin_step(input int unsigned min_us,
                                                  input int unsigned max_us,
                                                  input int unsigned num_classes);
        return (max_us - min_us) / (num_classes - 1);
    endfunction

    function automatic logic [CNT_W-1:0] bin_width(input logic [CNT_W-1:0] k,
                                                   input int unsigned   min_us,
                                                   input logic [CNT_W-1:0] step);
        return min_us + k * step;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multi_bin_sort_sequencer_servo_pwm_gen.sv
`default_nettype none
// ============================================================================
// servo_pwm_gen : us tick divider, PWM period counter, boundary-latched width
// Revision 1.0
// ============================================================================
module servo_pwm_gen
    import sort_seq_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 100,
    parameter int unsigned PERIOD_US = 20000,
    parameter int unsigned HOME_US   = 1500
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] target_w,
    output logic             servo_pwm,
    output logic             period_end
);

    logic [CNT_W-1:0] r_tick_cnt;
    logic [CNT_W-1:0] r_us_cnt;
    logic [CNT_W-1:0] r_width_q;
    logic             w_us_tick;

    assign w_us_tick  = (r_tick_cnt == TICK_DIV - 1);
    assign period_end = w_us_tick && (r_us_cnt == PERIOD_US - 1);

    // Width only changes at a period boundary so a pulse is never cut short or stretched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt <= '0;
            r_us_cnt   <= '0;
            r_width_q  <= HOME_US;
            servo_pwm  <= 1'b0;
        end else begin
            r_tick_cnt <= w_us_tick ? '0 : r_tick_cnt + CNT_W'(1);
            if (w_us_tick) begin
                r_us_cnt <= period_end ? '0 : r_us_cnt + CNT_W'(1);
            end
            if (period_end) begin
                r_width_q <= target_w;
            end
            servo_pwm <= (r_us_cnt < r_width_q);
        end
    end

endmodule
`default_nettype wire

// File: rtl/multi_bin_sort_sequencer.sv
`default_nettype none
// ============================================================================
// multi_bin_sort_sequencer : queues class detections, runs move/dwell/return
// Revision 1.0
// ============================================================================
module multi_bin_sort_sequencer
    import sort_seq_pkg::*;
#(
    parameter int unsigned TICK_DIV       = 100,
    parameter int unsigned PERIOD_US      = 20000,
    parameter int unsigned HOME_US        = 1500,
    parameter int unsigned MIN_US         = 1000,
    parameter int unsigned MAX_US         = 2000,
    parameter int unsigned NUM_CLASSES    = 4,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned SETTLE_PERIODS = 25,
    parameter int unsigned DWELL_PERIODS  = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic                           cls_valid,
    input  logic [$clog2(NUM_CLASSES)-1:0] cls_id,
    output logic                           cls_ready,
    output logic                           servo_pwm,
    output logic                           busy,
    output logic [$clog2(NUM_CLASSES)-1:0] cur_bin,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
    output logic                           bad_id
);

    localparam int unsigned      ID_W = $clog2(NUM_CLASSES);
    localparam int unsigned      AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned      LW   = AW + 1;
    localparam logic [CNT_W-1:0] STEP = bin_step(MIN_US, MAX_US, NUM_CLASSES);

    logic [ID_W-1:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [LW-1:0]    r_level;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_period_cnt;
    logic [CNT_W-1:0] w_target_w;
    logic [CNT_W-1:0] w_bin_w;
    logic             w_accept;
    logic             w_id_ok;
    logic             w_push;
    logic             w_pop;
    logic             w_period_end;

    assign cls_ready  = (CNT_W'(r_level) < FIFO_DEPTH);
    assign fifo_level = r_level;
    assign busy       = (r_state != IDLE);
    assign w_accept   = cls_valid && cls_ready;
    assign w_id_ok    = (CNT_W'(cls_id) < NUM_CLASSES);
    assign w_push     = w_accept && w_id_ok;
    assign w_pop      = (r_state == IDLE) && enable && (r_level != '0);
    assign w_bin_w    = bin_width(CNT_W'(cur_bin), MIN_US, STEP);

    // Out-of-range ids are consumed from the handshake but never queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
            bad_id   <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= cls_id;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
            if (w_accept && !w_id_ok) begin
                bad_id <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_period_cnt <= '0;
            cur_bin      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_period_cnt <= '0;
            end else if (w_period_end) begin
                r_period_cnt <= r_period_cnt + CNT_W'(1);
            end
            if (w_pop) begin
                cur_bin <= r_mem[r_rd_ptr];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_target_w  = HOME_US;
        case (r_state)
            IDLE: begin
                if (w_pop) w_state_nxt = MOVE;
            end
            MOVE: begin
                w_target_w = w_bin_w;
                if (r_period_cnt == SETTLE_PERIODS) w_state_nxt = HOLD;
            end
            HOLD: begin
                w_target_w = w_bin_w;
                if (r_period_cnt == DWELL_PERIODS) w_state_nxt = RETURN;
            end
            RETURN: begin
                if (r_period_cnt == SETTLE_PERIODS) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    servo_pwm_gen #(
        .TICK_DIV  (TICK_DIV),
        .PERIOD_US (PERIOD_US),
        .HOME_US   (HOME_US)
    ) u_pwm (
        .clk        (clk),
        .rst        (rst),
        .target_w   (w_target_w),
        .servo_pwm  (servo_pwm),
        .period_end (w_period_end)
    );

endmodule
`default_nettype wire

// File: tb/tb_multi_bin_sort_sequencer.sv
`default_nettype none
// ============================================================================
// tb_multi_bin_sort_sequencer : directed scenarios with hand-computed pulse widths
// Revision 1.0
// ============================================================================
module tb_multi_bin_sort_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       cls_valid = 1'b0;
    logic [1:0] cls_id = '0;
    logic       cls_ready, servo_pwm, busy, bad_id;
    logic [1:0] cur_bin;
    logic [2:0] fifo_level;

    // Five-class instance gives a 3-bit id port, so out-of-range ids can be driven.
    logic       enable5 = 1'b0;
    logic       valid5 = 1'b0;
    logic [2:0] id5 = '0;
    logic       ready5, pwm5, busy5, bad5;
    logic [2:0] cur_bin5;
    logic [2:0] level5;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int r0 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multi_bin_sort_sequencer #(
        .TICK_DIV(1), .PERIOD_US(100), .HOME_US(5), .MIN_US(10), .MAX_US(40),
        .NUM_CLASSES(4), .FIFO_DEPTH(4), .SETTLE_PERIODS(2), .DWELL_PERIODS(3)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .cls_valid(cls_valid), .cls_id(cls_id),
        .cls_ready(cls_ready), .servo_pwm(servo_pwm), .busy(busy), .cur_bin(cur_bin),
        .fifo_level(fifo_level), .bad_id(bad_id)
    );

    multi_bin_sort_sequencer #(
        .TICK_DIV(1), .PERIOD_US(100), .HOME_US(5), .MIN_US(10), .MAX_US(40),
        .NUM_CLASSES(5), .FIFO_DEPTH(4), .SETTLE_PERIODS(2), .DWELL_PERIODS(3)
    ) dut5 (
        .clk(clk), .rst(rst), .enable(enable5), .cls_valid(valid5), .cls_id(id5),
        .cls_ready(ready5), .servo_pwm(pwm5), .busy(busy5), .cur_bin(cur_bin5),
        .fifo_level(level5), .bad_id(bad5)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; cls_valid = 1'b0; enable5 = 1'b0; valid5 = 1'b0;
        tick(1);
        rst = 1'b0;
        r0 = cyc;
    endtask

    // Waits for the next rising edge of servo_pwm and measures its high time.
    task automatic get_pulse(output int w, output int st);
        logic prev;
        int   n;
        w = -1; st = -1; n = 0;
        prev = servo_pwm;
        while (!(!prev && servo_pwm) && n < 300) begin
            prev = servo_pwm;
            tick(1);
            n++;
        end
        checks++;
        if (!(!prev && servo_pwm)) begin
            errors++;
            $display("FAIL pulse_rise_timeout at cycle %0d", cyc);
        end else begin
            st = cyc; w = 0;
            while (servo_pwm && w < 300) begin
                w++;
                tick(1);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (servo_pwm !== 1'b0) begin errors++; $display("FAIL reset_pwm got %b want 0", servo_pwm); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (cls_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", cls_ready); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
        checks++; if (bad_id !== 1'b0) begin errors++; $display("FAIL reset_bad_id got %b want 0", bad_id); end
        checks++; if (cur_bin !== 2'd0) begin errors++; $display("FAIL reset_cur_bin got %0d want 0", cur_bin); end
    endtask

    task automatic test_idle_home();
        int w0, s0, w1, s1;
        get_pulse(w0, s0);
        get_pulse(w1, s1);
        checks++; if (w0 != 5) begin errors++; $display("FAIL home_w0 got %0d want 5", w0); end
        checks++; if (s0 != r0 + 1) begin errors++; $display("FAIL home_start got %0d want %0d", s0, r0 + 1); end
        checks++; if (w1 != 5) begin errors++; $display("FAIL home_w1 got %0d want 5", w1); end
        checks++; if (s1 - s0 != 100) begin errors++; $display("FAIL home_period got %0d want 100", s1 - s0); end
        checks++; if (busy !== 1'b0 || fifo_level !== 3'd0 || cls_ready !== 1'b1) begin
            errors++; $display("FAIL home_status got busy=%b lvl=%0d rdy=%b want 0/0/1", busy, fifo_level, cls_ready);
        end
    endtask

    task automatic test_single();
        int w, st;
        int exp_w[7] = '{30, 30, 30, 30, 30, 5, 5};
        do_reset();
        enable = 1'b1; cls_valid = 1'b1; cls_id = 2'd2;
        tick(1);
        cls_valid = 1'b0;
        checks++; if (fifo_level !== 3'd1 || busy !== 1'b0) begin
            errors++; $display("FAIL single_accept got lvl=%0d busy=%b want 1/0", fifo_level, busy);
        end
        tick(1);
        checks++; if (busy !== 1'b1 || fifo_level !== 3'd0 || cur_bin !== 2'd2) begin
            errors++; $display("FAIL single_pop got busy=%b lvl=%0d bin=%0d want 1/0/2", busy, fifo_level, cur_bin);
        end
        for (int i = 0; i < 7; i++) begin
            get_pulse(w, st);
            checks++; if (w != exp_w[i]) begin errors++; $display("FAIL single_w%0d got %0d want %0d", i, w, exp_w[i]); end
            if (i == 0) begin
                checks++; if (st != r0 + 101) begin errors++; $display("FAIL single_first_start got %0d want %0d", st, r0 + 101); end
            end
            if (i == 5) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_return got %b want 1", busy); end
            end
        end
        checks++; if (busy !== 1'b0 || cur_bin !== 2'd2) begin
            errors++; $display("FAIL single_done got busy=%b bin=%0d want 0/2", busy, cur_bin);
        end
    endtask

    task automatic test_back_to_back();
        int w, st;
        int ids[4]   = '{0, 1, 3, 2};
        int widths[4] = '{10, 20, 40, 30};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cls_valid = 1'b1; cls_id = 2'(ids[i]);
            checks++; if (cls_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d got %b want 1", i, cls_ready); end
            tick(1);
        end
        cls_id = 2'd1;
        checks++; if (cls_ready !== 1'b0 || fifo_level !== 3'd4) begin
            errors++; $display("FAIL b2b_full got rdy=%b lvl=%0d want 0/4", cls_ready, fifo_level);
        end
        tick(1);
        cls_valid = 1'b0;
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL b2b_no_overflow got %0d want 4", fifo_level); end
        enable = 1'b1;
        tick(1);
        checks++; if (fifo_level !== 3'd3 || busy !== 1'b1 || cur_bin !== 2'd0) begin
            errors++; $display("FAIL b2b_pop got lvl=%0d busy=%b bin=%0d want 3/1/0", fifo_level, busy, cur_bin);
        end
        for (int g = 0; g < 4; g++) begin
            for (int p = 0; p < 7; p++) begin
                get_pulse(w, st);
                checks++; if (w != ((p < 5) ? widths[g] : 5)) begin
                    errors++; $display("FAIL b2b_g%0d_p%0d got %0d want %0d", g, p, w, (p < 5) ? widths[g] : 5);
                end
                if (p == 0) begin
                    checks++; if (cur_bin !== 2'(ids[g])) begin errors++; $display("FAIL b2b_bin%0d got %0d want %0d", g, cur_bin, ids[g]); end
                end
            end
        end
        checks++; if (busy !== 1'b0 || fifo_level !== 3'd0) begin
            errors++; $display("FAIL b2b_done got busy=%b lvl=%0d want 0/0", busy, fifo_level);
        end
    endtask

    task automatic test_mid_period();
        int hi, w, st;
        // Pop while the home pulse is still high: that pulse must stay 5 wide.
        do_reset();
        enable = 1'b1; cls_valid = 1'b1; cls_id = 2'd3;
        tick(1);
        cls_valid = 1'b0;
        hi = 0;
        for (int k = 1; k < 100; k++) begin
            if (servo_pwm) hi++;
            tick(1);
        end
        checks++; if (hi != 5) begin errors++; $display("FAIL mid_early_cur got %0d want 5", hi); end
        get_pulse(w, st);
        checks++; if (w != 40 || st != r0 + 101) begin
            errors++; $display("FAIL mid_early_next got w=%0d st=%0d want 40/%0d", w, st, r0 + 101);
        end
        // Pop at us_cnt=50: nothing more in this period, width 40 from the next us_cnt=0.
        do_reset();
        enable = 1'b1;
        tick(48);
        cls_valid = 1'b1; cls_id = 2'd3;
        tick(1);
        cls_valid = 1'b0;
        tick(1);
        checks++; if (busy !== 1'b1 || servo_pwm !== 1'b0) begin
            errors++; $display("FAIL mid50_pop got busy=%b pwm=%b want 1/0", busy, servo_pwm);
        end
        hi = 0;
        for (int k = 50; k < 100; k++) begin
            if (servo_pwm) hi++;
            tick(1);
        end
        checks++; if (hi != 0) begin errors++; $display("FAIL mid50_rest got %0d want 0", hi); end
        get_pulse(w, st);
        checks++; if (w != 40 || st != r0 + 101) begin
            errors++; $display("FAIL mid50_next got w=%0d st=%0d want 40/%0d", w, st, r0 + 101);
        end
    endtask

    task automatic test_bad_id();
        do_reset();
        checks++; if (bad5 !== 1'b0 || ready5 !== 1'b1) begin
            errors++; $display("FAIL bad_reset got bad=%b rdy=%b want 0/1", bad5, ready5);
        end
        valid5 = 1'b1; id5 = 3'd5;
        tick(1);
        checks++; if (level5 !== 3'd0 || bad5 !== 1'b1) begin
            errors++; $display("FAIL bad_id5 got lvl=%0d bad=%b want 0/1", level5, bad5);
        end
        id5 = 3'd7;
        tick(1);
        checks++; if (level5 !== 3'd0 || bad5 !== 1'b1) begin
            errors++; $display("FAIL bad_id7 got lvl=%0d bad=%b want 0/1", level5, bad5);
        end
        id5 = 3'd4;
        tick(1);
        valid5 = 1'b0;
        tick(3);
        checks++; if (level5 !== 3'd1 || bad5 !== 1'b1) begin
            errors++; $display("FAIL bad_sticky got lvl=%0d bad=%b want 1/1", level5, bad5);
        end
        checks++; if (bad_id !== 1'b0) begin errors++; $display("FAIL bad_other_dut got %b want 0", bad_id); end
        do_reset();
        checks++; if (bad5 !== 1'b0 || level5 !== 3'd0) begin
            errors++; $display("FAIL bad_cleared got bad=%b lvl=%0d want 0/0", bad5, level5);
        end
    endtask

    task automatic test_reset_mid();
        int w, st, w1, s1;
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            cls_valid = 1'b1; cls_id = 2'(i);
            tick(1);
        end
        cls_valid = 1'b0;
        enable = 1'b1;
        tick(1);
        tick(296);
        checks++; if (busy !== 1'b1 || fifo_level !== 3'd2 || cur_bin !== 2'd1) begin
            errors++; $display("FAIL rmid_hold got busy=%b lvl=%0d bin=%0d want 1/2/1", busy, fifo_level, cur_bin);
        end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        r0 = cyc;
        checks++; if (busy !== 1'b0 || fifo_level !== 3'd0 || servo_pwm !== 1'b0 || cls_ready !== 1'b1 || cur_bin !== 2'd0) begin
            errors++; $display("FAIL rmid_after got busy=%b lvl=%0d pwm=%b rdy=%b bin=%0d want 0/0/0/1/0",
                               busy, fifo_level, servo_pwm, cls_ready, cur_bin);
        end
        get_pulse(w, st);
        get_pulse(w1, s1);
        checks++; if (w != 5 || st != r0 + 1) begin
            errors++; $display("FAIL rmid_home0 got w=%0d st=%0d want 5/%0d", w, st, r0 + 1);
        end
        checks++; if (w1 != 5 || s1 != r0 + 101 || busy !== 1'b0) begin
            errors++; $display("FAIL rmid_home1 got w=%0d st=%0d busy=%b want 5/%0d/0", w1, s1, busy, r0 + 101);
        end
    endtask

    initial begin
        test_reset();
        test_idle_home();
        test_single();
        test_back_to_back();
        test_mid_period();
        test_bad_id();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire
